// File: rtl/hwpe_stream_fifo_monitor.sv
// Occupancy and health monitor for a HWPE-Stream FIFO.
// Tracks fill level, high-water mark and sticky overflow/underflow errors.
module hwpe_stream_fifo_monitor #(
   parameter int unsigned FIFO_DEPTH = 8,
   localparam int unsigned CNT_WIDTH = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 clear_i,
   input  logic                 push_valid_i,
   input  logic                 push_ready_i,
   input  logic                 pop_valid_i,
   input  logic                 pop_ready_i,
   input  logic [CNT_WIDTH-1:0] almost_full_thr_i,
   input  logic [CNT_WIDTH-1:0] almost_empty_thr_i,
   input  logic                 wm_clear_i,
   input  logic                 err_clear_i,
   output logic [CNT_WIDTH-1:0] count_o,
   output logic                 almost_full_o,
   output logic                 almost_empty_o,
   output logic [CNT_WIDTH-1:0] watermark_o,
   output logic                 overflow_o,
   output logic                 underflow_o
);

   localparam logic [CNT_WIDTH-1:0] DEPTH = CNT_WIDTH'(FIFO_DEPTH);
   localparam logic [CNT_WIDTH-1:0] ONE   = CNT_WIDTH'(1);

   logic [CNT_WIDTH-1:0] count_q, count_d;
   logic [CNT_WIDTH-1:0] watermark_q, watermark_d;
   logic                 overflow_q, overflow_d;
   logic                 underflow_q, underflow_d;
   logic                 push, pop;
   logic                 ovf_evt, unf_evt;

   assign push = push_valid_i & push_ready_i;
   assign pop  = pop_valid_i & pop_ready_i;

   always_comb begin
      count_d = count_q;
      ovf_evt = 1'b0;
      unf_evt = 1'b0;
      if (push && !pop) begin
         if (count_q == DEPTH) ovf_evt = 1'b1;
         else                  count_d = count_q + ONE;
      end
      if (pop && !push) begin
         if (count_q == '0) unf_evt = 1'b1;
         else               count_d = count_q - ONE;
      end
   end

   always_comb begin
      watermark_d = watermark_q;
      if (wm_clear_i || count_d > watermark_q) watermark_d = count_d;
   end

   // a same-cycle error event outranks err_clear_i
   assign overflow_d  = ovf_evt | (overflow_q  & ~err_clear_i);
   assign underflow_d = unf_evt | (underflow_q & ~err_clear_i);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q     <= '0;
         watermark_q <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else if (clear_i) begin
         count_q     <= '0;
         watermark_q <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         count_q     <= count_d;
         watermark_q <= watermark_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign count_o        = count_q;
   assign watermark_o    = watermark_q;
   assign overflow_o     = overflow_q;
   assign underflow_o    = underflow_q;
   assign almost_full_o  = count_q >= almost_full_thr_i;
   assign almost_empty_o = count_q <= almost_empty_thr_i;

endmodule

// File: tb/tb_hwpe_stream_fifo_monitor.sv
// Directed bench for hwpe_stream_fifo_monitor.
// Expected outputs are queued when a step is driven and checked after the edge.
module tb_hwpe_stream_fifo_monitor;

   localparam int D  = 8;
   localparam int CW = $clog2(D + 1);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          clear = 1'b0;
   logic          pv = 1'b0, pr = 1'b0, qv = 1'b0, qr = 1'b0;
   logic [CW-1:0] thr_f = '0, thr_e = '0;
   logic          wm_clr = 1'b0, err_clr = 1'b0;
   logic [CW-1:0] count, wmark;
   logic          af, ae, ovf, unf;

   hwpe_stream_fifo_monitor #(.FIFO_DEPTH(D)) dut (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
      .push_valid_i(pv), .push_ready_i(pr),
      .pop_valid_i(qv), .pop_ready_i(qr),
      .almost_full_thr_i(thr_f), .almost_empty_thr_i(thr_e),
      .wm_clear_i(wm_clr), .err_clear_i(err_clr),
      .count_o(count), .almost_full_o(af), .almost_empty_o(ae),
      .watermark_o(wmark), .overflow_o(ovf), .underflow_o(unf)
   );

   always #5 clk = ~clk;

   typedef struct {
      string tag;
      int    cnt, wm;
      bit    ovf, unf, af, ae;
   } exp_t;

   exp_t sb[$];
   int   n_total = 0, n_pass = 0, n_fail = 0;
   int   m_cnt = 0, m_wm = 0;
   bit   m_ovf = 0, m_unf = 0;

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] expv);
      n_total++;
      assert (obs === expv) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic step(input string tag, input bit p, input bit o,
                       input bit wc = 0, input bit ec = 0, input bit cl = 0);
      exp_t e;
      int   nc;
      @(negedge clk);
      pv = p; pr = p; qv = o; qr = o;
      wm_clr = wc; err_clr = ec; clear = cl;
      if (cl) begin
         m_cnt = 0; m_wm = 0; m_ovf = 0; m_unf = 0;
      end else begin
         nc = m_cnt;
         m_ovf = m_ovf && !ec;
         m_unf = m_unf && !ec;
         if (p && !o) begin
            if (m_cnt == D) m_ovf = 1; else nc = m_cnt + 1;
         end
         if (o && !p) begin
            if (m_cnt == 0) m_unf = 1; else nc = m_cnt - 1;
         end
         m_cnt = nc;
         m_wm = (wc || nc > m_wm) ? nc : m_wm;
      end
      e.tag = tag; e.cnt = m_cnt; e.wm = m_wm;
      e.ovf = m_ovf; e.unf = m_unf;
      e.af = m_cnt >= int'(thr_f);
      e.ae = m_cnt <= int'(thr_e);
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 8'd1, 8'd0);
      end else begin
         e = sb.pop_front();
         chk({e.tag, "_count"}, 8'(count), 8'(e.cnt));
         chk({e.tag, "_wm"},    8'(wmark), 8'(e.wm));
         chk({e.tag, "_ovf"},   8'(ovf),   8'(e.ovf));
         chk({e.tag, "_unf"},   8'(unf),   8'(e.unf));
         chk({e.tag, "_af"},    8'(af),    8'(e.af));
         chk({e.tag, "_ae"},    8'(ae),    8'(e.ae));
      end
      pv = 0; pr = 0; qv = 0; qr = 0;
      wm_clr = 0; err_clr = 0; clear = 0;
   endtask

   initial begin
      thr_f = 0; thr_e = 1;
      #12;
      chk("rst_count", 8'(count), 8'd0);
      chk("rst_wm",    8'(wmark), 8'd0);
      chk("rst_ovf",   8'(ovf),   8'd0);
      chk("rst_unf",   8'(unf),   8'd0);
      chk("rst_ae",    8'(ae),    8'd1);
      chk("rst_af_thr0", 8'(af),  8'd1);
      thr_f = 6;
      #1;
      chk("rst_af_thr6", 8'(af),  8'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 1; i <= 6; i++) step($sformatf("fill%0d", i), 1, 0);
      chk("fill6_af", 8'(af), 8'd1);
      chk("fill6_wm", 8'(wmark), 8'd6);
      step("fill7", 1, 0);
      step("fill8", 1, 0);
      step("ovf_push", 1, 0);
      chk("ovf_cnt8", 8'(count), 8'd8);
      chk("ovf_set", 8'(ovf), 8'd1);
      step("ovf_hold", 0, 0);
      chk("ovf_persist", 8'(ovf), 8'd1);
      step("ovf_clr", 0, 0, 0, 1);
      chk("ovf_cleared", 8'(ovf), 8'd0);

      for (int i = 0; i < 8; i++) step($sformatf("drain%0d", i), 0, 1);
      step("unf_pop", 0, 1);
      chk("unf_set", 8'(unf), 8'd1);
      chk("unf_cnt0", 8'(count), 8'd0);
      step("unf_clr_pop", 0, 1, 0, 1);
      chk("unf_wins", 8'(unf), 8'd1);
      step("unf_clr", 0, 0, 0, 1);

      for (int i = 0; i < 3; i++) step("to3", 1, 0);
      for (int i = 0; i < 5; i++) step("both3", 1, 1);
      chk("both3_cnt", 8'(count), 8'd3);
      chk("both3_wm", 8'(wmark), 8'd8);
      for (int i = 0; i < 5; i++) step("to8", 1, 0);
      for (int i = 0; i < 5; i++) step("both8", 1, 1);
      chk("both8_cnt", 8'(count), 8'd8);
      chk("both8_ovf", 8'(ovf), 8'd0);
      chk("both8_unf", 8'(unf), 8'd0);

      thr_f = 15; thr_e = 9;
      #1;
      chk("thr_hi_af", 8'(af), 8'd0);
      chk("thr_hi_ae", 8'(ae), 8'd1);
      thr_f = 6; thr_e = 1;

      step("clr0", 0, 0, 0, 0, 1);
      for (int i = 0; i < 5; i++) step("to5", 1, 0);
      for (int i = 0; i < 3; i++) step("to2", 0, 1);
      step("wmclr", 0, 0, 1);
      chk("wmclr_wm2", 8'(wmark), 8'd2);
      step("wm_push", 1, 0);
      chk("wm_push3", 8'(wmark), 8'd3);

      for (int i = 0; i < 5; i++) step("refill", 1, 0);
      step("ovf2", 1, 0);
      for (int i = 0; i < 4; i++) step("to4", 0, 1);
      chk("pre_clr_cnt4", 8'(count), 8'd4);
      chk("pre_clr_ovf", 8'(ovf), 8'd1);
      step("clr_push", 1, 0, 1, 1, 1);
      chk("clr_cnt", 8'(count), 8'd0);
      chk("clr_ovf", 8'(ovf), 8'd0);
      chk("clr_wm", 8'(wmark), 8'd0);

      step("a1", 1, 0);
      step("a2", 1, 0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("async_rst_cnt", 8'(count), 8'd0);
      chk("async_rst_wm", 8'(wmark), 8'd0);
      m_cnt = 0; m_wm = 0; m_ovf = 0; m_unf = 0;
      @(negedge clk);
      rst_n = 1'b1;
      step("post_rst", 1, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
